mem_bank_rmw_adapter: RTL
=========================

MEM_BANK_RMW_ADAPTER -- requirements
Module: mem_bank_rmw_adapter

Interface
REQ-001: Parameter AddrWidth, default 32, byte address width of bank request port.
REQ-002: Parameter DataWidth, default 32, bank word width; power of two, multiple of 8.
REQ-003: Parameter NumWords, default 1024, SRAM depth; MemAddrWidth = max(1, clog2(NumWords)).
REQ-004: Parameter UserWidth, default 1, sideband width; wuser_i returned unchanged on ruser_o.
REQ-005: clk_i  input  1  clock; all state on its rising edge.
REQ-006: rst_ni  input  1  reset; one clock, reset asynchronous and active-low.
REQ-007: req_i  input  1  bank request valid.
REQ-008: gnt_o  output  1  request accepted this cycle when req_i & gnt_o.
REQ-009: addr_i  input  AddrWidth  byte address.
REQ-010: wdata_i  input  DataWidth  write data.
REQ-011: strb_i  input  DataWidth/8  byte write strobe.
REQ-012: wuser_i  input  UserWidth  request sideband.
REQ-013: we_i  input  1  write enable, active high.
REQ-014: rvalid_o  output  1  response valid, for reads and writes; no backpressure.
REQ-015: rdata_o  output  DataWidth  read data; '0 for writes.
REQ-016: ruser_o  output  UserWidth  sideband of the answered request.
REQ-017: mem_req_o  output  1  SRAM access strobe.
REQ-018: mem_we_o  output  1  SRAM full-word write enable; the SRAM has no byte enables.
REQ-019: mem_addr_o  output  MemAddrWidth  SRAM word address.
REQ-020: mem_wdata_o  output  DataWidth  SRAM write data.
REQ-021: mem_rdata_i  input  DataWidth  SRAM read data, valid exactly 1 cycle after a read strobe.

Function
REQ-022: Word address = addr_i >> clog2(DataWidth/8), truncated to MemAddrWidth bits; upper bits ignored (wrap).
REQ-023: FSM states IDLE and MERGE; gnt_o = 1 in IDLE, 0 in MERGE.
REQ-024: IDLE, accepted read: mem_req_o=1, mem_we_o=0 same cycle; next cycle rvalid_o=1, rdata_o=mem_rdata_i.
REQ-025: IDLE, accepted write with strb_i all ones: mem_req_o=1, mem_we_o=1, mem_wdata_o=wdata_i same cycle; next cycle rvalid_o=1, rdata_o='0.
REQ-026: IDLE, accepted write with strb_i == '0: no SRAM access; next cycle rvalid_o=1, rdata_o='0.
REQ-027: IDLE, accepted partial-strobe write: SRAM read of target word same cycle; word address, wdata, strb, wuser captured; next state MERGE.
REQ-028: MERGE (exactly 1 cycle): mem_req_o=1, mem_we_o=1, same word address, mem_wdata_o byte b = strb[b] ? captured wdata byte b : mem_rdata_i byte b; next state IDLE; rvalid_o=1 the following cycle.
REQ-029: IDLE with req_i=0, or any state with no access due: mem_req_o=0, mem_we_o=0.
REQ-030: Responses strictly in request order, one per accepted request, ruser_o = that request's wuser_i.
REQ-031: Throughput: reads/full/zero-strobe writes 1 per cycle; partial writes 1 per 2 cycles.
REQ-032: Request accepted in the cycle after MERGE sees the merged word (write precedes it at the SRAM).
REQ-033: rvalid_o, rdata_o, ruser_o are registered outputs; mem_* outputs are combinational from state and request inputs.
REQ-034: Outstanding responses never exceed 1; no internal FIFO.

Reset
REQ-035: During reset: state=IDLE, rvalid_o=0, rdata_o='0, ruser_o='0, captured registers '0.
REQ-036: Reset asserted in MERGE: pending merge write discarded, no rvalid_o after reset release.
REQ-037: First cycle after reset release: gnt_o=1, mem_req_o=req_i.

Verification
REQ-038: Full write addr 0x10 data 0xDEADBEEF strb 0xF, then read 0x10 -> mem_addr_o=4 both; read rvalid_o with rdata_o=0xDEADBEEF, 1 cycle after read.
REQ-039: Word 4 = 0xDEADBEEF; write 0x10 data 0x000000AA strb 0x1 -> gnt_o=0 next cycle, MERGE writes 0xDEADBEAA, rvalid_o 2 cycles after accept; read returns 0xDEADBEAA.
REQ-040: Write strb 0x0 to 0x20 -> mem_req_o=0, rvalid_o next cycle, SRAM word 8 unchanged.
REQ-041: Back-to-back partial write then read of same address, req_i held high -> read granted in cycle after MERGE, returns merged data; responses in order with matching ruser_o.
REQ-042: Address 0x1010 with NumWords=1024 -> mem_addr_o=4 (wrap).
REQ-043: Reset pulsed during MERGE -> no SRAM write on that cycle after reset assertion, rvalid_o=0, gnt_o=1 after release.

Source files
------------

// File: rtl/mem_bank_rmw_adapter.sv
// Byte-strobed bank port onto a word-only SRAM; partial writes become read-modify-write.
// Latency: 1 cycle (reads/full/zero-strobe), 2 cycles (partial); gnt_o drops for the merge cycle.
module mem_bank_rmw_adapter #(
  parameter int unsigned AddrWidth = 32,
  parameter int unsigned DataWidth = 32,
  parameter int unsigned NumWords  = 1024,
  parameter int unsigned UserWidth = 1,
  localparam int unsigned NumBytes     = DataWidth / 8,
  localparam int unsigned MemAddrWidth = (NumWords > 1) ? $clog2(NumWords) : 1
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    req_i,
  output logic                    gnt_o,
  input  logic [AddrWidth-1:0]    addr_i,
  input  logic [DataWidth-1:0]    wdata_i,
  input  logic [NumBytes-1:0]     strb_i,
  input  logic [UserWidth-1:0]    wuser_i,
  input  logic                    we_i,
  output logic                    rvalid_o,
  output logic [DataWidth-1:0]    rdata_o,
  output logic [UserWidth-1:0]    ruser_o,
  output logic                    mem_req_o,
  output logic                    mem_we_o,
  output logic [MemAddrWidth-1:0] mem_addr_o,
  output logic [DataWidth-1:0]    mem_wdata_o,
  input  logic [DataWidth-1:0]    mem_rdata_i
);

  localparam int unsigned OffWidth = $clog2(NumBytes);

  typedef enum logic {
    IDLE  = 1'b0,
    MERGE = 1'b1
  } state_e;

  state_e state_q, state_d;

  logic [MemAddrWidth-1:0] word_addr;
  logic                    strb_full;
  logic                    strb_zero;
  logic                    strb_part;

  logic [MemAddrWidth-1:0] cap_addr_q;
  logic [DataWidth-1:0]    cap_wdata_q;
  logic [NumBytes-1:0]     cap_strb_q;
  logic [UserWidth-1:0]    cap_user_q;
  logic [DataWidth-1:0]    merged_wdata;

  logic                    rvalid_q;
  logic                    rread_q;
  logic [UserWidth-1:0]    ruser_q;

  // Upper address bits beyond the SRAM depth are dropped, so addresses wrap.
  assign word_addr = MemAddrWidth'(addr_i >> OffWidth);
  assign strb_full = &strb_i;
  assign strb_zero = ~|strb_i;
  assign strb_part = !strb_full && !strb_zero;

  always_comb begin
    merged_wdata = '0;
    for (int b = 0; b < NumBytes; b++) begin
      merged_wdata[b*8 +: 8] = cap_strb_q[b] ? cap_wdata_q[b*8 +: 8] : mem_rdata_i[b*8 +: 8];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (req_i && we_i && strb_part) begin
          state_d = MERGE;
        end
      end
      MERGE:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    gnt_o       = 1'b0;
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = word_addr;
    mem_wdata_o = wdata_i;
    case (state_q)
      IDLE: begin
        gnt_o = 1'b1;
        if (req_i) begin
          if (!we_i) begin
            mem_req_o = 1'b1;
          end else if (strb_full) begin
            mem_req_o = 1'b1;
            mem_we_o  = 1'b1;
          end else if (strb_part) begin
            mem_req_o = 1'b1;
          end
        end
      end
      MERGE: begin
        mem_req_o   = 1'b1;
        mem_we_o    = 1'b1;
        mem_addr_o  = cap_addr_q;
        mem_wdata_o = merged_wdata;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cap_addr_q  <= '0;
      cap_wdata_q <= '0;
      cap_strb_q  <= '0;
      cap_user_q  <= '0;
      rvalid_q    <= 1'b0;
      rread_q     <= 1'b0;
      ruser_q     <= '0;
    end else begin
      rvalid_q <= 1'b0;
      rread_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (req_i) begin
            if (we_i && strb_part) begin
              cap_addr_q  <= word_addr;
              cap_wdata_q <= wdata_i;
              cap_strb_q  <= strb_i;
              cap_user_q  <= wuser_i;
            end else begin
              rvalid_q <= 1'b1;
              rread_q  <= !we_i;
              ruser_q  <= wuser_i;
            end
          end
        end
        MERGE: begin
          rvalid_q <= 1'b1;
          ruser_q  <= cap_user_q;
        end
        default: ;
      endcase
    end
  end

  // The SRAM output is itself a register one cycle after the strobe, so it is
  // steered straight out rather than re-registered (which would add a cycle).
  assign rvalid_o = rvalid_q;
  assign rdata_o  = rread_q ? mem_rdata_i : '0;
  assign ruser_o  = ruser_q;

endmodule
